tex_flash_burst_reader: RTL and testbench

//  Parametrised SPI flash texture fetcher. It issues a read command and an address, then streams a burst of

---
 rtl/tex_flash_burst_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_tex_flash_burst_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_flash_burst_reader.sv
// -----------------------------------------------------------------------------
// tex_flash_burst_reader
//
// SPI flash texture fetcher. A request latches a byte address and a read mode,
// the block then clocks out a read command and the address on io0, optionally
// waits out the dummy clocks, and streams BURST_LEN words of WORD_W bits back
// to the texture logic, one rd_valid_o pulse per word.
//
// Read modes (req_mode_i): 0 = single (0x03, data on io1)
//                          1 = dual   (0x3B, data on io1:io0)
//                          2 = quad   (0x6B, data on io3:io0)
//                          3 = treated as single
//
// SCLK runs at clk/2: every SPI bit is one low-phase cycle followed by one
// high-phase cycle. Pad outputs only change when a low phase begins, and
// inputs are sampled at the clock edge that ends a high phase.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset; aborts any burst at once
//   req_i          start request, only looked at in IDLE
//   req_addr_i     start byte address, captured with req_i
//   req_mode_i     read mode, captured with req_i
//   busy_o         high from the accept cycle until IDLE is re-entered
//   rd_data_o      last assembled word, held between valids
//   rd_valid_o     one-cycle pulse per word
//   done_o         one-cycle pulse in the cycle CSb rises after the last word
//   spi_csb_o      flash chip select, active low
//   spi_sclk_o     flash clock, idles low
//   spi_io_out_o   io[3:0] output values
//   spi_io_oe_o    io[3:0] output enables (1 = drive)
//   spi_io_in_i    io[3:0] sampled pad values
// -----------------------------------------------------------------------------
module tex_flash_burst_reader #(
    parameter int ADDR_W       = 24,
    parameter int WORD_W       = 8,
    parameter int BURST_LEN    = 4,
    parameter int DUMMY_CLKS   = 8,
    parameter int CS_HIGH_CLKS = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_mode_i,
    output logic              busy_o,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic              spi_csb_o,
    output logic              spi_sclk_o,
    output logic [3:0]        spi_io_out_o,
    output logic [3:0]        spi_io_oe_o,
    input  logic [3:0]        spi_io_in_i
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int MAX_AW  = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
    localparam int MAX_AWD = (MAX_AW > DUMMY_CLKS) ? MAX_AW : DUMMY_CLKS;
    localparam int MAX_CNT = (MAX_AWD > 8) ? MAX_AWD : 8;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int WCNT_W  = $clog2(BURST_LEN + 1);
    localparam int HCNT_W  = $clog2(CS_HIGH_CLKS + 1);
    localparam int TX_W    = 8 + ADDR_W;
    localparam int DUMMY_M1 = (DUMMY_CLKS > 0) ? (DUMMY_CLKS - 1) : 0;

    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DUMMY_LAST = CNT_W'(DUMMY_M1);
    localparam logic [CNT_W-1:0]  SPW1_LAST  = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  SPW2_LAST  = CNT_W'(WORD_W / 2 - 1);
    localparam logic [CNT_W-1:0]  SPW4_LAST  = CNT_W'(WORD_W / 4 - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST  = WCNT_W'(BURST_LEN - 1);
    localparam logic [HCNT_W-1:0] CSH_LAST   = HCNT_W'(CS_HIGH_CLKS - 1);

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_DUAL   = 2'd1;
    localparam logic [1:0] MODE_QUAD   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_CSH   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Read command opcode for a (normalised) mode.
    function automatic logic [7:0] cmd_for_mode(input logic [1:0] mode);
        logic [7:0] cmd;
        case (mode)
            MODE_DUAL: cmd = 8'h3B;
            MODE_QUAD: cmd = 8'h6B;
            default:   cmd = 8'h03;
        endcase
        return cmd;
    endfunction

    // Shift one SCLK worth of sampled lanes into the word, MSB first.
    // The concatenation is padded so every branch has the same width,
    // which keeps the slice legal even for WORD_W = 4.
    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] word,
                                                   input logic [3:0]        io,
                                                   input logic [1:0]        mode);
        logic [WORD_W+3:0] tmp;
        case (mode)
            MODE_DUAL: tmp = {2'b00, word, io[1:0]};
            MODE_QUAD: tmp = {word, io};
            default:   tmp = {3'b000, word, io[1]};
        endcase
        return tmp[WORD_W-1:0];
    endfunction

    // Index of the last SCLK of a word for the given mode.
    function automatic logic [CNT_W-1:0] word_last_for_mode(input logic [1:0] mode);
        logic [CNT_W-1:0] last;
        case (mode)
            MODE_DUAL: last = SPW2_LAST;
            MODE_QUAD: last = SPW4_LAST;
            default:   last = SPW1_LAST;
        endcase
        return last;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [HCNT_W-1:0]  csh_cnt_q,  csh_cnt_d;
    logic [1:0]         mode_q,     mode_d;
    logic [TX_W-1:0]    tx_q,       tx_d;
    logic [WORD_W-1:0]  shift_q,    shift_d;
    logic [WORD_W-1:0]  rd_data_q,  rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               done_q,     done_d;
    logic               busy_q,     busy_d;
    logic               csb_q,      csb_d;
    logic               sclk_q,     sclk_d;
    logic [3:0]         io_out_q,   io_out_d;
    logic [3:0]         io_oe_q,    io_oe_d;

    logic [1:0]         req_mode_s;
    logic [7:0]         req_cmd_s;
    logic [WORD_W-1:0]  shifted_s;

    // Mode 3 is folded into single so the rest of the logic sees three modes.
    assign req_mode_s = (req_mode_i == 2'd3) ? MODE_SINGLE : req_mode_i;
    assign req_cmd_s  = cmd_for_mode(req_mode_s);
    assign shifted_s  = shift_in(shift_q, spi_io_in_i, mode_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        csh_cnt_d  = csh_cnt_q;
        mode_d     = mode_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        csb_d      = csb_q;
        sclk_d     = sclk_q;
        io_out_d   = io_out_q;
        io_oe_d    = io_oe_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    // First command bit goes out with the CSb fall; the rest
                    // of command+address waits in tx_q, MSB at the top.
                    state_d    = ST_CMD;
                    mode_d     = req_mode_s;
                    tx_d       = {req_cmd_s[6:0], req_addr_i, 1'b0};
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    csb_d      = 1'b0;
                    sclk_d     = 1'b0;
                    io_out_d   = {1'b1, 1'b1, 1'b0, req_cmd_s[7]};
                    io_oe_d    = 4'b1101;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (!sclk_q) begin
                    // End of low phase: raise SCLK, nothing else moves.
                    sclk_d = 1'b1;
                end else begin
                    // End of high phase: sample, then set up the next bit.
                    sclk_d = 1'b0;
                    case (state_q)
                        ST_CMD: begin
                            io_out_d[0] = tx_q[TX_W-1];
                            tx_d        = {tx_q[TX_W-2:0], 1'b0};
                            if (bit_cnt_q == CMD_LAST) begin
                                state_d   = ST_ADDR;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                        ST_ADDR: begin
                            if (bit_cnt_q == ADDR_LAST) begin
                                bit_cnt_d   = '0;
                                io_out_d[0] = 1'b0;
                                io_oe_d[0]  = 1'b0;
                                // Quad reads hand io2/io3 to the flash from here on.
                                if (mode_q == MODE_QUAD) begin
                                    io_oe_d[3:2]  = 2'b00;
                                    io_out_d[3:2] = 2'b00;
                                end else begin
                                    io_oe_d[3:2]  = 2'b11;
                                    io_out_d[3:2] = 2'b11;
                                end
                                if ((mode_q != MODE_SINGLE) && (DUMMY_CLKS > 0)) begin
                                    state_d = ST_DUMMY;
                                end else begin
                                    state_d = ST_DATA;
                                end
                            end else begin
                                io_out_d[0] = tx_q[TX_W-1];
                                tx_d        = {tx_q[TX_W-2:0], 1'b0};
                                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                            end
                        end
                        ST_DUMMY: begin
                            if (bit_cnt_q == DUMMY_LAST) begin
                                state_d   = ST_DATA;
                                bit_cnt_d = '0;
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                        ST_DATA: begin
                            shift_d = shifted_s;
                            if (bit_cnt_q == word_last_for_mode(mode_q)) begin
                                // Word complete: present it next cycle.
                                // Words run back to back, no gap SCLKs.
                                bit_cnt_d  = '0;
                                rd_data_d  = shifted_s;
                                rd_valid_d = 1'b1;
                                if (word_cnt_q == WORD_LAST) begin
                                    state_d   = ST_CSH;
                                    csh_cnt_d = '0;
                                    csb_d     = 1'b1;
                                    io_out_d  = 4'b0000;
                                    io_oe_d   = 4'b0000;
                                    done_d    = 1'b1;
                                end else begin
                                    word_cnt_d = word_cnt_q + WCNT_W'(1);
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_CSH: begin
                // The done cycle counts as the first CSb-high cycle.
                if (csh_cnt_q == CSH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    csh_cnt_d = csh_cnt_q + HCNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                csb_d    = 1'b1;
                sclk_d   = 1'b0;
                io_out_d = 4'b0000;
                io_oe_d  = 4'b0000;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            csh_cnt_q  <= '0;
            mode_q     <= MODE_SINGLE;
            tx_q       <= '0;
            shift_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            csb_q      <= 1'b1;
            sclk_q     <= 1'b0;
            io_out_q   <= 4'b0000;
            io_oe_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            csh_cnt_q  <= csh_cnt_d;
            mode_q     <= mode_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            csb_q      <= csb_d;
            sclk_q     <= sclk_d;
            io_out_q   <= io_out_d;
            io_oe_q    <= io_oe_d;
        end
    end

    assign busy_o       = busy_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign done_o       = done_q;
    assign spi_csb_o    = csb_q;
    assign spi_sclk_o   = sclk_q;
    assign spi_io_out_o = io_out_q;
    assign spi_io_oe_o  = io_oe_q;

endmodule

// File: tb/tb_tex_flash_burst_reader.sv
// Bench for tex_flash_burst_reader: small SPI flash model plus a timed
// scoreboard of expected words.
module tb_tex_flash_burst_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [23:0] req_addr;
    logic [1:0]  req_mode;
    logic        busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        spi_csb;
    logic        spi_sclk;
    logic [3:0]  spi_io_out;
    logic [3:0]  spi_io_oe;
    logic [3:0]  spi_io_in = 4'b1000;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tex_flash_burst_reader dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_mode_i   (req_mode),
        .busy_o       (busy),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .done_o       (done),
        .spi_csb_o    (spi_csb),
        .spi_sclk_o   (spi_sclk),
        .spi_io_out_o (spi_io_out),
        .spi_io_oe_o  (spi_io_oe),
        .spi_io_in_i  (spi_io_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         t;
        bit         last;
    } exp_t;
    exp_t sb[$];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hA5;
            24'h000101: return 8'h3C;
            24'h000102: return 8'h0F;
            24'h000103: return 8'hF0;
            default:    return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- flash model ----------------
    int          fn = 0;
    int          f_hdr, f_lanes, f_p;
    logic [7:0]  f_b;
    logic [7:0]  fm_cmd = 8'h00;
    logic [23:0] fm_addr = 24'h0;
    logic [7:0]  cap_cmd = 8'h00;
    logic [23:0] cap_addr = 24'h0;

    always @(posedge spi_sclk or posedge spi_csb) begin
        if (spi_csb) begin
            fn        = 0;
            fm_cmd    = 8'h00;
            fm_addr   = 24'h0;
            spi_io_in = 4'b1000;
        end else begin
            if (fn < 8) fm_cmd = {fm_cmd[6:0], spi_io_out[0]};
            else if (fn < 32) fm_addr = {fm_addr[22:0], spi_io_out[0]};
            if (fn == 31) begin
                cap_cmd  = fm_cmd;
                cap_addr = fm_addr;
            end
            f_lanes = (fm_cmd == 8'h3B) ? 2 : ((fm_cmd == 8'h6B) ? 4 : 1);
            f_hdr   = (f_lanes == 1) ? 32 : 40;
            if (fn >= f_hdr) begin
                f_p = (fn - f_hdr) * f_lanes;
                f_b = mem_byte(fm_addr + 24'(f_p / 8));
                f_b = f_b << (f_p % 8);
                case (f_lanes)
                    1:       spi_io_in = {1'b1, 1'b0, f_b[7], 1'b0};
                    2:       spi_io_in = {1'b1, 1'b0, f_b[7], f_b[6]};
                    default: spi_io_in = f_b[7:4];
                endcase
            end
            fn++;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("stray_valid", {31'b0, rd_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_data", {24'b0, rd_data}, {24'b0, e.data});
                    chk("valid_time", cyc, e.t);
                    chk("done_with_last", {31'b0, done}, {31'b0, e.last});
                end
            end else if (done) begin
                chk("stray_done", {31'b0, done}, 32'd0);
            end
            if (done) begin
                chk("done_csb",  {31'b0, spi_csb},  32'd1);
                chk("done_sclk", {31'b0, spi_sclk}, 32'd0);
                chk("done_oe",   {28'b0, spi_io_oe}, 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input logic [1:0] m, input logic [23:0] a, input int e);
        int first, per;
        case (m)
            2'd1:    begin first = 88; per = 8;  end
            2'd2:    begin first = 84; per = 4;  end
            default: begin first = 80; per = 16; end
        endcase
        for (int w = 0; w < 4; w++) begin
            exp_t x;
            x.data = mem_byte(a + 24'(w));
            x.t    = e + first + w * per;
            x.last = (w == 3);
            sb.push_back(x);
        end
    endtask

    task automatic start_req(input logic [1:0] m, input logic [23:0] a, input bit hold, output int e);
        @(negedge clk);
        req      = 1'b1;
        req_mode = m;
        req_addr = a;
        @(posedge clk);
        #1;
        e = cyc;
        if (!hold) req = 1'b0;
        push_exp(m, a, e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        chk("drain_sb", sb.size(), 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    int e0, e1, e2;

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        req_addr = 24'h0;
        req_mode = 2'd0;
        #1;
        chk("rst_csb",    {31'b0, spi_csb},   32'd1);
        chk("rst_sclk",   {31'b0, spi_sclk},  32'd0);
        chk("rst_oe",     {28'b0, spi_io_oe}, 32'd0);
        chk("rst_out",    {28'b0, spi_io_out}, 32'd0);
        chk("rst_busy",   {31'b0, busy},      32'd0);
        chk("rst_valid",  {31'b0, rd_valid},  32'd0);
        chk("rst_done",   {31'b0, done},      32'd0);
        chk("rst_rddata", {24'b0, rd_data},   32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-lane read
        start_req(2'd0, 24'h000100, 1'b0, e0);
        chk("m0_csb_low", {31'b0, spi_csb},    32'd0);
        chk("m0_busy",    {31'b0, busy},       32'd1);
        chk("m0_oe",      {28'b0, spi_io_oe},  32'hD);
        chk("m0_out",     {28'b0, spi_io_out}, 32'hC);
        wait_done(400);
        chk("m0_cmd",  {24'b0, cap_cmd}, 32'h03);
        chk("m0_addr", {8'b0, cap_addr}, 32'h000100);

        // Dual read: io2/io3 stay driven high
        start_req(2'd1, 24'h000100, 1'b0, e0);
        wait_until(e0 + 63);
        chk("m1_oe_addr",  {28'b0, spi_io_oe}, 32'hD);
        wait_until(e0 + 64);
        chk("m1_oe_dummy", {28'b0, spi_io_oe}, 32'hC);
        chk("m1_out_dummy", {28'b0, spi_io_out}, 32'hC);
        wait_done(400);
        chk("m1_cmd", {24'b0, cap_cmd}, 32'h3B);

        // Quad read: io2/io3 released at dummy start
        start_req(2'd2, 24'h000100, 1'b0, e0);
        wait_until(e0 + 63);
        chk("m2_oe_addr",  {28'b0, spi_io_oe}, 32'hD);
        wait_until(e0 + 64);
        chk("m2_oe_dummy", {28'b0, spi_io_oe}, 32'h0);
        wait_done(400);
        chk("m2_cmd", {24'b0, cap_cmd}, 32'h6B);

        // Dual read at another address
        start_req(2'd1, 24'h000102, 1'b0, e0);
        wait_done(400);
        chk("m1b_addr", {8'b0, cap_addr}, 32'h000102);

        // req held high across a whole transaction
        start_req(2'd0, 24'h000100, 1'b1, e1);
        wait_until(e1 + 129);
        chk("hold_csh_csb",   {31'b0, spi_csb}, 32'd1);
        chk("hold_csh_busy",  {31'b0, busy},    32'd1);
        wait_until(e1 + 130);
        chk("hold_idle_csb",  {31'b0, spi_csb}, 32'd1);
        chk("hold_idle_busy", {31'b0, busy},    32'd0);
        @(negedge clk);
        e2 = e1 + 131;
        chk("hold_reaccept_time", cyc, e2);
        chk("hold_reaccept_csb",  {31'b0, spi_csb}, 32'd0);
        chk("hold_reaccept_busy", {31'b0, busy},    32'd1);
        req = 1'b0;
        push_exp(2'd0, 24'h000100, e2);
        wait_done(400);

        // Reset during the second data word
        start_req(2'd0, 24'h000100, 1'b0, e0);
        wait_until(e0 + 88);
        reset = 1'b1;
        #1;
        chk("abort_csb",  {31'b0, spi_csb},   32'd1);
        chk("abort_sclk", {31'b0, spi_sclk},  32'd0);
        chk("abort_oe",   {28'b0, spi_io_oe}, 32'd0);
        chk("abort_busy", {31'b0, busy},      32'd0);
        chk("abort_data", {24'b0, rd_data},   32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_idle_csb", {31'b0, spi_csb}, 32'd1);
        start_req(2'd0, 24'h000100, 1'b0, e0);
        wait_done(400);

        // Mode 3 behaves as single
        start_req(2'd3, 24'h000100, 1'b0, e0);
        chk("m3_oe", {28'b0, spi_io_oe}, 32'hD);
        wait_done(400);
        chk("m3_cmd",  {24'b0, cap_cmd}, 32'h03);
        chk("m3_addr", {8'b0, cap_addr}, 32'h000100);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
